// File: rtl/debug_event_writer.sv
`default_nettype none
// ============================================================================
// Module   : debug_event_writer
// Purpose  : Queues hardware debug events and replays them as single-beat
//            writes on the shared PE debug port via a request/grant handshake.
//            Optional macro DEBUG_EVT_DROP_CNT_EN: drop-when-full with counter.
// Revision : 1.0 - initial release
// ============================================================================
module debug_event_writer #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ev_valid_i,
    output logic        ev_ready_o,
    input  logic [3:0]  ev_kind_i,
    input  logic [31:0] ev_data_i,
    output logic        req_o,
    input  logic        gnt_i,
    output logic        en_o,
    output logic        we_o,
    output logic [23:0] addr_o,
    output logic [31:0] data_o,
    output logic        err_o,
`ifdef DEBUG_EVT_DROP_CNT_EN
    output logic [15:0] drop_cnt_o,
`endif
    output logic        halted_o
);

    localparam int unsigned c_ptr_w = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};
    localparam int unsigned c_ent_w = 1 + 8 + 32;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_req    = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_ptr_w:0]   r_wr_ptr;
    logic [c_ptr_w:0]   r_rd_ptr;
    logic [c_ptr_w:0]   w_wr_ptr_nxt;
    logic [c_ptr_w:0]   w_rd_ptr_nxt;
    logic [c_ent_w-1:0] r_mem [DEPTH];
    logic               r_halt_seen;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_kind_ok;
    logic               w_is_halt;
    logic [7:0]         w_off;
    logic [31:0]        w_pdata;
    logic [c_ent_w-1:0] w_head;
    logic               w_head_halt;
    logic [7:0]         w_head_off;
    logic [31:0]        w_head_data;
    logic               w_req;
    logic               w_beat;

    // Offsets and packing match the software-visible logger register map
    always_comb begin
        w_kind_ok = 1'b1;
        w_is_halt = 1'b0;
        w_off     = 8'h00;
        w_pdata   = ev_data_i;
        case (ev_kind_i)
            4'd0: w_pdata = {24'h000000, ev_data_i[7:0]};
            4'd1: begin
                w_off     = 8'h04;
                w_pdata   = 32'h0000_0000;
                w_is_halt = 1'b1;
            end
            4'd2: w_off = 8'h10;
            4'd3: w_off = 8'h20;
            4'd4: w_off = 8'h24;
            4'd5: w_off = 8'h30;
            4'd6: w_off = 8'h34;
            4'd7: w_off = 8'h40;
            4'd8: w_off = 8'h44;
            default: begin
                w_kind_ok = 1'b0;
                w_pdata   = 32'h0000_0000;
            end
        endcase
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);

`ifdef DEBUG_EVT_DROP_CNT_EN
    // A halt must never be lost, so it alone still sees backpressure when full
    assign w_ready = !r_halt_seen && !(w_full && w_is_halt);
`else
    assign w_ready = !w_full && !r_halt_seen;
`endif

    assign w_accept = ev_valid_i && w_ready;
    assign w_push   = w_accept && w_kind_ok && !w_full;
    assign w_pop    = w_beat;

    assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + c_ptr_one) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_halt_seen <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_err    <= w_accept && !w_kind_ok;
            if (w_push && w_is_halt) begin
                r_halt_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= {w_is_halt, w_off, w_pdata};
        end
    end

    assign w_head      = r_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign w_head_halt = w_head[c_ent_w-1];
    assign w_head_off  = w_head[39:32];
    assign w_head_data = w_head[31:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IDLE also requests when data is present, giving next-cycle request latency
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            c_st_idle, c_st_req: begin
                if (!w_empty) begin
                    w_req = 1'b1;
                    if (gnt_i) begin
                        w_beat = 1'b1;
                        if (w_head_halt) begin
                            w_state_nxt = c_st_halted;
                        end else if (w_wr_ptr_nxt != w_rd_ptr_nxt) begin
                            w_state_nxt = c_st_req;
                        end else begin
                            w_state_nxt = c_st_idle;
                        end
                    end else begin
                        w_state_nxt = c_st_req;
                    end
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_halted: w_state_nxt = c_st_halted;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

`ifdef DEBUG_EVT_DROP_CNT_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = w_accept && w_kind_ok && w_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= 16'h0000;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'h0001;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`endif

    assign ev_ready_o = w_ready;
    assign req_o      = w_req;
    assign en_o       = w_beat;
    assign we_o       = w_beat;
    assign addr_o     = w_beat ? (BASE_ADDR + {16'h0000, w_head_off}) : 24'h000000;
    assign data_o     = w_beat ? w_head_data : 32'h0000_0000;
    assign err_o      = r_err;
    assign halted_o   = (r_state == c_st_halted);

endmodule
`default_nettype wire

// File: tb/tb_debug_event_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_event_writer
// Purpose  : Scoreboard bench for debug_event_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_event_writer;

    localparam int          DEPTH     = 8;
    localparam logic [23:0] BASE_ADDR = 24'h000000;
`ifdef DEBUG_EVT_DROP_CNT_EN
    localparam bit          DROP_MODE = 1'b1;
`else
    localparam bit          DROP_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        ev_valid_i;
    logic        ev_ready_o;
    logic [3:0]  ev_kind_i;
    logic [31:0] ev_data_i;
    logic        req_o;
    logic        gnt_i;
    logic        en_o;
    logic        we_o;
    logic [23:0] addr_o;
    logic [31:0] data_o;
    logic        err_o;
    logic        halted_o;
`ifdef DEBUG_EVT_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    always #5 clk = ~clk;

    debug_event_writer #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .ev_valid_i (ev_valid_i),
        .ev_ready_o (ev_ready_o),
        .ev_kind_i  (ev_kind_i),
        .ev_data_i  (ev_data_i),
        .req_o      (req_o),
        .gnt_i      (gnt_i),
        .en_o       (en_o),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .err_o      (err_o),
`ifdef DEBUG_EVT_DROP_CNT_EN
        .drop_cnt_o (drop_cnt_o),
`endif
        .halted_o   (halted_o)
    );

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_addr(input logic [3:0] k);
        logic [23:0] off;
        case (k)
            4'd0: off = 24'h00;
            4'd1: off = 24'h04;
            4'd2: off = 24'h10;
            4'd3: off = 24'h20;
            4'd4: off = 24'h24;
            4'd5: off = 24'h30;
            4'd6: off = 24'h34;
            4'd7: off = 24'h40;
            4'd8: off = 24'h44;
            default: off = 24'h00;
        endcase
        return BASE_ADDR + off;
    endfunction

    function automatic logic [31:0] exp_data(input logic [3:0] k, input logic [31:0] d);
        if (k == 4'd0) return {24'h000000, d[7:0]};
        if (k == 4'd1) return 32'h0;
        return d;
    endfunction

    // Offer one event; called and returns just after a rising edge
    task automatic send(input logic [3:0] k, input logic [31:0] d, input logic exp_rdy,
                        input logic exp_store, input string tag);
        beat_t e;
        ev_valid_i = 1'b1;
        ev_kind_i  = k;
        ev_data_i  = d;
        @(negedge clk);
        check(tag, ev_ready_o, exp_rdy);
        if (exp_rdy && exp_store) begin
            e.addr = exp_addr(k);
            e.data = exp_data(k, d);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        ev_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            if (en_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", en_o, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("beat_addr", addr_o, mon_e.addr);
                    check("beat_data", data_o, mon_e.data);
                    check("beat_we", we_o, 1'b1);
                end
            end else begin
                check("idle_bus_zero", {addr_o, data_o}, 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni     = 1'b0;
        ev_valid_i = 1'b0;
        ev_kind_i  = 4'd0;
        ev_data_i  = 32'h0;
        gnt_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        @(negedge clk);
        check("rst_ready", ev_ready_o, 1'b1);
        check("rst_req", req_o, 1'b0);
        check("rst_en", en_o, 1'b0);
        check("rst_halted", halted_o, 1'b0);
        check("rst_err", err_o, 1'b0);
`ifdef DEBUG_EVT_DROP_CNT_EN
        check("rst_drop_cnt", drop_cnt_o, 16'h0);
`endif
        @(posedge clk);
        #1;

        // Single event with grant held: beat on the very next cycle
        gnt_i = 1'b1;
        send(4'd3, 32'h0005_0002, 1'b1, 1'b1, "rdy_single");
        @(negedge clk);
        check("lat_en", en_o, 1'b1);
        check("lat_addr", addr_o, 24'h000020);
        check("lat_data", data_o, 32'h0005_0002);
        @(negedge clk);
        check("req_after_beat", req_o, 1'b0);
        @(posedge clk);
        #1;

        // Fill the FIFO with grant withheld, then drain at full rate
        gnt_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(4'((i % 7) + 2), 32'hA000_0000 + 32'(i * 32'h0001_0011),
                 1'b1, 1'b1, "rdy_fill");
        end
        send(4'd5, 32'h1111_2222, DROP_MODE, 1'b0, "rdy_when_full");
`ifdef DEBUG_EVT_DROP_CNT_EN
        send(4'd6, 32'h3333_4444, 1'b1, 1'b0, "rdy_drop2");
        send(4'd0, 32'h0000_0055, 1'b1, 1'b0, "rdy_drop3");
        send(4'd1, 32'h0, 1'b0, 1'b0, "rdy_halt_full");
        @(negedge clk);
        check("drop_cnt", drop_cnt_o, 16'd3);
        @(posedge clk);
        #1;
`endif
        gnt_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("drain_back_to_back", en_o, 1'b1);
        end
        @(negedge clk);
        check("drain_done_en", en_o, 1'b0);
        check("drain_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // Invalid kind: consumed, err pulse, no beat
        send(4'd12, 32'hDEAD_BEEF, 1'b1, 1'b0, "rdy_invalid");
        @(negedge clk);
        check("err_pulse", err_o, 1'b1);
        @(negedge clk);
        check("err_clear", err_o, 1'b0);
        @(posedge clk);
        #1;

        // Char, halt, char: the second char is refused after the halt
        gnt_i = 1'b0;
        send(4'd0, 32'hFFFF_FF41, 1'b1, 1'b1, "rdy_char_a");
        send(4'd1, 32'h1234_5678, 1'b1, 1'b1, "rdy_halt");
        send(4'd0, 32'h0000_0042, 1'b0, 1'b1, "rdy_char_b");
        gnt_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("halt_seq_en", en_o, 1'b1);
        end
        @(negedge clk);
        check("halted", halted_o, 1'b1);
        check("halted_req", req_o, 1'b0);
        check("halted_ready", ev_ready_o, 1'b0);
        check("halt_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a pending request
        rst_ni = 1'b0;
        gnt_i  = 1'b0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        check("rst2_halted", halted_o, 1'b0);
        check("rst2_ready", ev_ready_o, 1'b1);
        @(posedge clk);
        #1;
        send(4'd5, 32'h0001_0001, 1'b1, 1'b1, "rdy_q1");
        send(4'd6, 32'h0002_0002, 1'b1, 1'b1, "rdy_q2");
        send(4'd7, 32'h0003_0003, 1'b1, 1'b1, "rdy_q3");
        @(negedge clk);
        check("pending_req", req_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        gnt_i  = 1'b1;
        #1;
        check("async_rst_req", req_o, 1'b0);
        check("async_rst_en", en_o, 1'b0);
        sb.delete();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_beat", en_o, 1'b0);
            check("post_rst_no_req", req_o, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
